// File: rtl/control_seq_if.sv
// Control/handshake bundle between the instruction sequencer and ROM, RAM, register file and ALU.
interface control_seq_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  localparam int unsigned INSTR_W = 16 + DATA_W;

  logic [ADDR_W-1:0]  romAdd;
  logic               romReq;
  logic               romValid;
  logic [INSTR_W-1:0] romData;
  logic [ADDR_W-1:0]  ramAdd;
  logic               ramRead;
  logic               ramWrite;
  logic               ramAck;
  logic [DATA_W-1:0]  dout;
  logic [DATA_W-1:0]  greg;
  logic [2:0]         operand1;
  logic [2:0]         operand2;
  logic [2:0]         results;
  logic [5:0]         aluOperation;
  logic [3:0]         aluParams;
  logic               aluStart;
  logic               aluBusy;
  logic               aluReadBus;
  logic [3:0]         busState;
  logic               flagZ;
  logic               flagC;
  logic               halted;

  modport master (
    output romAdd, romReq, ramAdd, ramRead, ramWrite, dout,
           operand1, operand2, results, aluOperation, aluParams,
           aluStart, aluReadBus, busState, halted,
    input  romValid, romData, ramAck, greg, aluBusy, flagZ, flagC
  );

  modport slave (
    input  romAdd, romReq, ramAdd, ramRead, ramWrite, dout,
           operand1, operand2, results, aluOperation, aluParams,
           aluStart, aluReadBus, busState, halted,
    output romValid, romData, ramAck, greg, aluBusy, flagZ, flagC
  );
endinterface

// File: rtl/control_seq.sv
// Multi-cycle fetch/decode/execute sequencer for the console CPU.
// Every control output is a register; the next-state process computes all of them.
module control_seq #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic           CLK,
  input logic           RST,
  control_seq_if.master bus
);
  localparam int unsigned INSTR_W = 16 + DATA_W;

  localparam logic [4:0] OP_LDR = 5'h01, OP_STR = 5'h02, OP_ADD = 5'h03, OP_SUB = 5'h04;
  localparam logic [4:0] OP_MUL = 5'h05, OP_LDI = 5'h08, OP_ADI = 5'h09, OP_SBI = 5'h0A;
  localparam logic [4:0] OP_MLI = 5'h0B, OP_AND = 5'h0E, OP_OR  = 5'h0F, OP_XOR = 5'h10;
  localparam logic [4:0] OP_NOT = 5'h11, OP_ANI = 5'h12, OP_ORI = 5'h13, OP_XRI = 5'h14;
  localparam logic [4:0] OP_LSL = 5'h15, OP_LSR = 5'h16, OP_JMP = 5'h18, OP_BEQ = 5'h19;
  localparam logic [4:0] OP_BNE = 5'h1A, OP_BCS = 5'h1B, OP_LDG = 5'h1C, OP_STG = 5'h1D;
  localparam logic [4:0] OP_HLT = 5'h1F;

  localparam logic [5:0] ALU_PASS  = 6'b100000, ALU_ADD = 6'b100001, ALU_MUL = 6'b100010;
  localparam logic [5:0] ALU_LOGIC = 6'b100100, ALU_LSL = 6'b101000, ALU_LSR = 6'b110000;

  localparam logic [3:0] BUS_NONE = 4'd0, BUS_REG_RAM = 4'd1, BUS_RAM_ALU = 4'd2, BUS_IMM_ALU = 4'd6;

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;
  typedef enum logic [1:0] {DONE_NOW, DONE_ACK, DONE_ALU} done_t;

  state_t             state_q, state_d;
  done_t              done_q, done_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  logic [ADDR_W-1:0]  rom_add_q, rom_add_d;
  logic               rom_req_q, rom_req_d;
  logic [ADDR_W-1:0]  ram_add_q, ram_add_d;
  logic               ram_read_q, ram_read_d;
  logic               ram_write_q, ram_write_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic [2:0]         operand1_q, operand1_d;
  logic [2:0]         operand2_q, operand2_d;
  logic [2:0]         results_q, results_d;
  logic [5:0]         alu_op_q, alu_op_d;
  logic [3:0]         alu_params_q, alu_params_d;
  logic               alu_start_q, alu_start_d;
  logic               alu_read_bus_q, alu_read_bus_d;
  logic [3:0]         bus_state_q, bus_state_d;
  logic               halted_q, halted_d;

  logic [4:0]         op;
  logic [DATA_W-1:0]  word2;
  logic               alu_go;
  logic               imm;
  logic               complete;
  logic               taken;
  logic               unused_bits;

  assign op          = ir_q[5:1];
  assign word2       = ir_q[INSTR_W-1:16];
  assign unused_bits = ^{ir_q[6], ir_q[0], bus.greg};

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    done_d         = done_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    rom_add_d      = rom_add_q;
    rom_req_d      = rom_req_q;
    ram_add_d      = ram_add_q;
    ram_read_d     = ram_read_q;
    ram_write_d    = ram_write_q;
    dout_d         = dout_q;
    operand1_d     = operand1_q;
    operand2_d     = operand2_q;
    results_d      = results_q;
    alu_op_d       = alu_op_q;
    alu_params_d   = alu_params_q;
    alu_start_d    = 1'b0;
    alu_read_bus_d = alu_read_bus_q;
    bus_state_d    = bus_state_q;
    halted_d       = halted_q;
    alu_go         = 1'b0;
    imm            = 1'b0;
    complete       = 1'b0;
    taken          = 1'b0;

    case (op)
      OP_JMP:  taken = 1'b1;
      OP_BEQ:  taken = bus.flagZ;
      OP_BNE:  taken = !bus.flagZ;
      OP_BCS:  taken = bus.flagC;
      default: taken = 1'b0;
    endcase

    case (state_q)
      FETCH: begin
        if (bus.romValid) begin
          ir_d      = bus.romData;
          rom_req_d = 1'b0;
          state_d   = DECODE;
        end
      end

      DECODE: begin
        operand1_d     = ir_q[9:7];
        operand2_d     = ir_q[12:10];
        results_d      = ir_q[15:13];
        dout_d         = word2;
        alu_op_d       = '0;
        alu_params_d   = '0;
        bus_state_d    = BUS_NONE;
        alu_read_bus_d = 1'b0;
        ram_read_d     = 1'b0;
        ram_write_d    = 1'b0;
        done_d         = DONE_NOW;
        case (op)
          OP_LDR, OP_LDG: begin
            bus_state_d    = BUS_RAM_ALU;
            ram_read_d     = 1'b1;
            alu_read_bus_d = 1'b1;
            done_d         = DONE_ACK;
            ram_add_d      = (op == OP_LDG) ? bus.greg[ADDR_W-1:0] : word2[ADDR_W-1:0];
          end
          OP_STR, OP_STG: begin
            bus_state_d = BUS_REG_RAM;
            ram_write_d = 1'b1;
            done_d      = DONE_ACK;
            ram_add_d   = (op == OP_STG) ? bus.greg[ADDR_W-1:0] : word2[ADDR_W-1:0];
          end
          OP_ADD: begin alu_go = 1'b1; alu_op_d = ALU_ADD; end
          OP_SUB: begin alu_go = 1'b1; alu_op_d = ALU_ADD; alu_params_d = 4'd1; end
          OP_MUL: begin alu_go = 1'b1; alu_op_d = ALU_MUL; done_d = DONE_ALU; end
          OP_LDI: begin alu_go = 1'b1; imm = 1'b1; alu_op_d = ALU_PASS; end
          OP_ADI: begin alu_go = 1'b1; imm = 1'b1; alu_op_d = ALU_ADD; end
          OP_SBI: begin alu_go = 1'b1; imm = 1'b1; alu_op_d = ALU_ADD; alu_params_d = 4'd1; end
          OP_MLI: begin alu_go = 1'b1; imm = 1'b1; alu_op_d = ALU_MUL; done_d = DONE_ALU; end
          OP_AND: begin alu_go = 1'b1; alu_op_d = ALU_LOGIC; alu_params_d = 4'd0; end
          OP_OR:  begin alu_go = 1'b1; alu_op_d = ALU_LOGIC; alu_params_d = 4'd1; end
          OP_XOR: begin alu_go = 1'b1; alu_op_d = ALU_LOGIC; alu_params_d = 4'd2; end
          OP_NOT: begin alu_go = 1'b1; alu_op_d = ALU_LOGIC; alu_params_d = 4'd3; end
          OP_ANI: begin alu_go = 1'b1; imm = 1'b1; alu_op_d = ALU_LOGIC; alu_params_d = 4'd0; end
          OP_ORI: begin alu_go = 1'b1; imm = 1'b1; alu_op_d = ALU_LOGIC; alu_params_d = 4'd1; end
          OP_XRI: begin alu_go = 1'b1; imm = 1'b1; alu_op_d = ALU_LOGIC; alu_params_d = 4'd2; end
          OP_LSL: begin alu_go = 1'b1; alu_op_d = ALU_LSL; alu_params_d = word2[3:0]; end
          OP_LSR: begin alu_go = 1'b1; alu_op_d = ALU_LSR; alu_params_d = word2[3:0]; end
          default: ;
        endcase
        if (imm) begin
          bus_state_d    = BUS_IMM_ALU;
          alu_read_bus_d = 1'b1;
        end
        alu_start_d = alu_go;
        state_d     = EXEC;
      end

      EXEC: begin
        // aluBusy is only meaningful once the start pulse has been seen by the ALU
        case (done_q)
          DONE_ACK: complete = bus.ramAck;
          DONE_ALU: complete = !alu_start_q && !bus.aluBusy;
          default:  complete = 1'b1;
        endcase
        if (complete) begin
          pc_d           = taken ? word2[ADDR_W-1:0] : pc_q + ADDR_W'(1);
          ram_read_d     = 1'b0;
          ram_write_d    = 1'b0;
          alu_read_bus_d = 1'b0;
          if (op == OP_HLT) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            rom_req_d = 1'b1;
            rom_add_d = pc_d;
            state_d   = FETCH;
          end
        end
      end

      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= FETCH;
      done_q         <= DONE_NOW;
      pc_q           <= RESET_PC;
      ir_q           <= '0;
      rom_add_q      <= RESET_PC;
      rom_req_q      <= 1'b1;
      ram_add_q      <= '0;
      ram_read_q     <= 1'b0;
      ram_write_q    <= 1'b0;
      dout_q         <= '0;
      operand1_q     <= '0;
      operand2_q     <= '0;
      results_q      <= '0;
      alu_op_q       <= '0;
      alu_params_q   <= '0;
      alu_start_q    <= 1'b0;
      alu_read_bus_q <= 1'b0;
      bus_state_q    <= BUS_NONE;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      done_q         <= done_d;
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      rom_add_q      <= rom_add_d;
      rom_req_q      <= rom_req_d;
      ram_add_q      <= ram_add_d;
      ram_read_q     <= ram_read_d;
      ram_write_q    <= ram_write_d;
      dout_q         <= dout_d;
      operand1_q     <= operand1_d;
      operand2_q     <= operand2_d;
      results_q      <= results_d;
      alu_op_q       <= alu_op_d;
      alu_params_q   <= alu_params_d;
      alu_start_q    <= alu_start_d;
      alu_read_bus_q <= alu_read_bus_d;
      bus_state_q    <= bus_state_d;
      halted_q       <= halted_d;
    end
  end

  assign bus.romAdd       = rom_add_q;
  assign bus.romReq       = rom_req_q;
  assign bus.ramAdd       = ram_add_q;
  assign bus.ramRead      = ram_read_q;
  assign bus.ramWrite     = ram_write_q;
  assign bus.dout         = dout_q;
  assign bus.operand1     = operand1_q;
  assign bus.operand2     = operand2_q;
  assign bus.results      = results_q;
  assign bus.aluOperation = alu_op_q;
  assign bus.aluParams    = alu_params_q;
  assign bus.aluStart     = alu_start_q;
  assign bus.aluReadBus   = alu_read_bus_q;
  assign bus.busState     = bus_state_q;
  assign bus.halted       = halted_q;
endmodule
